// File: rtl/lb_arbiter.sv
// Two-master round-robin arbiter for a simple local bus.
// One owner at a time; an idle cycle always separates grants.
module lb_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_lb_waddr,
    input  logic [DATA_W-1:0] m0_lb_wdata,
    input  logic [STRB_W-1:0] m0_lb_wstrb,
    input  logic              m0_lb_wen,
    output logic              m0_lb_wready,
    input  logic [ADDR_W-1:0] m0_lb_raddr,
    input  logic              m0_lb_ren,
    output logic [DATA_W-1:0] m0_lb_rdata,
    output logic              m0_lb_rvalid,
    input  logic [ADDR_W-1:0] m1_lb_waddr,
    input  logic [DATA_W-1:0] m1_lb_wdata,
    input  logic [STRB_W-1:0] m1_lb_wstrb,
    input  logic              m1_lb_wen,
    output logic              m1_lb_wready,
    input  logic [ADDR_W-1:0] m1_lb_raddr,
    input  logic              m1_lb_ren,
    output logic [DATA_W-1:0] m1_lb_rdata,
    output logic              m1_lb_rvalid,
    output logic [ADDR_W-1:0] lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic [STRB_W-1:0] lb_wstrb,
    output logic              lb_wen,
    input  logic              lb_wready,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic              lb_ren,
    input  logic [DATA_W-1:0] lb_rdata,
    input  logic              lb_rvalid,
    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic       r_gnt_idx;
    logic       r_last;
    logic [1:0] r_gnt;

    logic              w_req0;
    logic              w_req1;
    logic              w_any_req;
    logic              w_win;
    logic              w_win_wen;
    logic [ADDR_W-1:0] w_sel_waddr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [STRB_W-1:0] w_sel_wstrb;
    logic              w_sel_wen;
    logic [ADDR_W-1:0] w_sel_raddr;
    logic              w_sel_ren;

    assign w_req0    = m0_lb_wen | m0_lb_ren;
    assign w_req1    = m1_lb_wen | m1_lb_ren;
    assign w_any_req = w_req0 | w_req1;
    assign gnt       = r_gnt;

    // Round-robin pick: a lone requester wins, otherwise the non-last master.
    always_comb begin
        w_win = w_req1;
        if (w_req0 && w_req1) begin
            w_win = ~r_last;
        end
        w_win_wen = w_win ? m1_lb_wen : m0_lb_wen;
    end

    // Steer the granted master's request fields toward the downstream bus.
    always_comb begin
        w_sel_waddr = r_gnt_idx ? m1_lb_waddr : m0_lb_waddr;
        w_sel_wdata = r_gnt_idx ? m1_lb_wdata : m0_lb_wdata;
        w_sel_wstrb = r_gnt_idx ? m1_lb_wstrb : m0_lb_wstrb;
        w_sel_wen   = r_gnt_idx ? m1_lb_wen   : m0_lb_wen;
        w_sel_raddr = r_gnt_idx ? m1_lb_raddr : m0_lb_raddr;
        w_sel_ren   = r_gnt_idx ? m1_lb_ren   : m0_lb_ren;
    end

    // Next state: grant from IDLE, leave on completion or a dropped request.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = w_win_wen ? WR : RD;
                end
            end
            WR: begin
                if (!w_sel_wen || lb_wready) begin
                    w_state_nxt = IDLE;
                end
            end
            RD: begin
                if (!w_sel_ren || lb_rvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, grant index, one-hot grant and last-winner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt_idx <= 1'b0;
            r_last    <= 1'b1;
            r_gnt     <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE) begin
                if (w_any_req) begin
                    r_gnt_idx <= w_win;
                    r_last    <= w_win;
                    r_gnt     <= w_win ? 2'b10 : 2'b01;
                end
            end else if (w_state_nxt == IDLE) begin
                r_gnt <= 2'b00;
            end
        end
    end

    // Bus forwarding; handshakes are gated by the live request so stray
    // ready/valid pulses never reach a master, and reset masks everything.
    always_comb begin
        lb_waddr     = '0;
        lb_wdata     = '0;
        lb_wstrb     = '0;
        lb_wen       = 1'b0;
        lb_raddr     = '0;
        lb_ren       = 1'b0;
        m0_lb_wready = 1'b0;
        m1_lb_wready = 1'b0;
        m0_lb_rvalid = 1'b0;
        m1_lb_rvalid = 1'b0;
        m0_lb_rdata  = '0;
        m1_lb_rdata  = '0;
        if (!rst) begin
            unique case (r_state)
                WR: begin
                    lb_waddr = w_sel_waddr;
                    lb_wdata = w_sel_wdata;
                    lb_wstrb = w_sel_wstrb;
                    lb_wen   = w_sel_wen;
                    if (r_gnt_idx) begin
                        m1_lb_wready = lb_wready & w_sel_wen;
                    end else begin
                        m0_lb_wready = lb_wready & w_sel_wen;
                    end
                end
                RD: begin
                    lb_raddr = w_sel_raddr;
                    lb_ren   = w_sel_ren;
                    if (r_gnt_idx) begin
                        m1_lb_rvalid = lb_rvalid & w_sel_ren;
                        m1_lb_rdata  = lb_rdata;
                    end else begin
                        m0_lb_rvalid = lb_rvalid & w_sel_ren;
                        m0_lb_rdata  = lb_rdata;
                    end
                end
                default: begin
                    lb_wen = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lb_arbiter.sv
// Scoreboard bench for lb_arbiter: directed scenarios plus random traffic
// from two masters against a wait-state slave and a round-robin model.
module tb_lb_arbiter;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] m_waddr [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    logic        m_wen   [2];
    logic        m_wready[2];
    logic [15:0] m_raddr [2];
    logic        m_ren   [2];
    logic [31:0] m_rdata [2];
    logic        m_rvalid[2];
    logic [15:0] lb_waddr;
    logic [31:0] lb_wdata;
    logic [3:0]  lb_wstrb;
    logic        lb_wen;
    logic        lb_wready = 1'b0;
    logic [15:0] lb_raddr;
    logic        lb_ren;
    logic [31:0] lb_rdata = 32'h0;
    logic        lb_rvalid = 1'b0;
    logic [1:0]  gnt;

    int tests = 0;
    int fails = 0;

    wexp_t       wq[2][$];
    logic [31:0] rq[2][$];
    logic [2:0]  glog[$];
    int          last_run = 0;

    int smode = 0;
    int fixed_wait = 0;
    bit spur_en = 1'b0;

    lb_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_lb_waddr(m_waddr[0]), .m0_lb_wdata(m_wdata[0]),
        .m0_lb_wstrb(m_wstrb[0]), .m0_lb_wen(m_wen[0]),
        .m0_lb_wready(m_wready[0]), .m0_lb_raddr(m_raddr[0]),
        .m0_lb_ren(m_ren[0]), .m0_lb_rdata(m_rdata[0]),
        .m0_lb_rvalid(m_rvalid[0]),
        .m1_lb_waddr(m_waddr[1]), .m1_lb_wdata(m_wdata[1]),
        .m1_lb_wstrb(m_wstrb[1]), .m1_lb_wen(m_wen[1]),
        .m1_lb_wready(m_wready[1]), .m1_lb_raddr(m_raddr[1]),
        .m1_lb_ren(m_ren[1]), .m1_lb_rdata(m_rdata[1]),
        .m1_lb_rvalid(m_rvalid[1]),
        .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb),
        .lb_wen(lb_wen), .lb_wready(lb_wready),
        .lb_raddr(lb_raddr), .lb_ren(lb_ren),
        .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void timeout(string nm);
        tests++;
        fails++;
        $display("FAIL %s: no handshake within cycle budget at %0t", nm, $time);
    endfunction

    // Slave memory contents seen by reads.
    function automatic logic [31:0] slave_data(input logic [15:0] a);
        case (a)
            16'h0008: return 32'hdeadbeef;
            16'h0014: return 32'hc0debabe;
            default:  return {a ^ 16'h5a5a, a};
        endcase
    endfunction

    // Slave: wait states per access, optional stray ready/valid when idle.
    // Modes: 0 random, 1 fixed wait, 2 never respond, 3 force ready/valid.
    int wcnt = 0, wtgt = 0, rcnt = 0, rtgt = 0;
    bit wact = 1'b0, ract = 1'b0;
    always @(posedge clk) begin
        #2;
        if (lb_wen) begin
            if (!wact) begin
                wact = 1'b1;
                wcnt = 0;
                wtgt = (smode == 1) ? fixed_wait : $urandom_range(0, 3);
            end
            lb_wready = (smode != 2) && (wcnt == wtgt);
            wcnt++;
        end else begin
            wact = 1'b0;
            lb_wready = (smode == 3) ||
                        (smode == 0 && spur_en && $urandom_range(0, 3) == 0);
        end
        if (lb_ren) begin
            if (!ract) begin
                ract = 1'b1;
                rcnt = 0;
                rtgt = (smode == 1) ? fixed_wait : $urandom_range(0, 3);
            end
            lb_rvalid = (smode != 2) && (rcnt == rtgt);
            rcnt++;
        end else begin
            ract = 1'b0;
            lb_rvalid = (smode == 3) ||
                        (smode == 0 && spur_en && $urandom_range(0, 3) == 0);
        end
        lb_rdata = (lb_ren && lb_rvalid) ? slave_data(lb_raddr) : $urandom;
    end

    // Monitor: round-robin ownership model plus response scoreboard.
    int   mg = -1;
    bit   mkw = 1'b0;
    bit   mlast = 1'b1;
    bit   p_rst = 1'b1;
    bit   p_wen[2] = '{1'b0, 1'b0};
    bit   p_ren[2] = '{1'b0, 1'b0};
    bit   p_wrdy = 1'b0, p_rvld = 1'b0;
    logic [1:0] p_dgnt = 2'b00;
    int   wen_run = 0;
    always @(negedge clk) begin
        bit held, done, e_w, e_r, r0, r1;
        int win;
        logic [1:0] e_gnt;
        wexp_t we;
        logic [31:0] re;
        r0 = p_wen[0] | p_ren[0];
        r1 = p_wen[1] | p_ren[1];
        if (p_rst) begin
            mg = -1;
            mlast = 1'b1;
        end else if (mg < 0) begin
            if (r0 || r1) begin
                if (r0 && r1) win = mlast ? 0 : 1;
                else win = r1 ? 1 : 0;
                mg = win;
                mlast = (win == 1);
                mkw = p_wen[win];
            end
        end else begin
            held = mkw ? p_wen[mg] : p_ren[mg];
            done = held && (mkw ? p_wrdy : p_rvld);
            if (!held || done) mg = -1;
        end
        e_gnt = (mg < 0) ? 2'b00 : ((mg == 1) ? 2'b10 : 2'b01);
        chk("gnt", gnt, e_gnt);
        e_w = !rst && mg >= 0 && mkw && m_wen[mg < 0 ? 0 : mg];
        e_r = !rst && mg >= 0 && !mkw && m_ren[mg < 0 ? 0 : mg];
        chk("lb_wen", lb_wen, e_w);
        chk("lb_ren", lb_ren, e_r);
        if (e_w) begin
            chk("lb_waddr", lb_waddr, m_waddr[mg]);
            chk("lb_wdata", lb_wdata, m_wdata[mg]);
            chk("lb_wstrb", lb_wstrb, m_wstrb[mg]);
            wen_run++;
        end else if (wen_run > 0) begin
            last_run = wen_run;
            wen_run = 0;
        end
        if (e_r) chk("lb_raddr", lb_raddr, m_raddr[mg]);
        if (gnt != 2'b00 && p_dgnt == 2'b00) glog.push_back({lb_wen, gnt});
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("m%0d_wready", n), m_wready[n],
                e_w && mg == n && lb_wready);
            chk($sformatf("m%0d_rvalid", n), m_rvalid[n],
                e_r && mg == n && lb_rvalid);
            if (mg != n || rst) chk($sformatf("m%0d_rdata_idle", n), m_rdata[n], 0);
            if (m_wready[n]) begin
                if (wq[n].size() == 0) begin
                    chk($sformatf("m%0d_wr_extra", n), m_wready[n], 0);
                end else begin
                    we = wq[n].pop_front();
                    chk($sformatf("m%0d_acc_waddr", n), lb_waddr, we.a);
                    chk($sformatf("m%0d_acc_wdata", n), lb_wdata, we.d);
                    chk($sformatf("m%0d_acc_wstrb", n), lb_wstrb, we.s);
                end
            end
            if (m_rvalid[n]) begin
                if (rq[n].size() == 0) begin
                    chk($sformatf("m%0d_rd_extra", n), m_rvalid[n], 0);
                end else begin
                    re = rq[n].pop_front();
                    chk($sformatf("m%0d_rdata", n), m_rdata[n], re);
                end
            end
        end
        p_rst = rst;
        for (int n = 0; n < 2; n++) begin
            p_wen[n] = m_wen[n];
            p_ren[n] = m_ren[n];
        end
        p_wrdy = lb_wready;
        p_rvld = lb_rvalid;
        p_dgnt = gnt;
    end

    // One master transaction: write, read, or write then read.
    task automatic txn(input int n, input bit dw, input bit dr,
                       input logic [15:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [15:0] ra);
        int k;
        @(posedge clk);
        #1;
        if (dw) begin
            m_waddr[n] = wa;
            m_wdata[n] = wd;
            m_wstrb[n] = ws;
            m_wen[n] = 1'b1;
            wq[n].push_back('{wa, wd, ws});
        end
        if (dr) begin
            m_raddr[n] = ra;
            m_ren[n] = 1'b1;
            rq[n].push_back(slave_data(ra));
        end
        if (dw) begin
            k = 0;
            forever begin
                @(negedge clk);
                if (m_wready[n]) break;
                if (++k > 300) begin
                    timeout($sformatf("m%0d_wr_timeout", n));
                    break;
                end
            end
            @(posedge clk);
            #1;
            m_wen[n] = 1'b0;
        end
        if (dr) begin
            k = 0;
            forever begin
                @(negedge clk);
                if (m_rvalid[n]) break;
                if (++k > 300) begin
                    timeout($sformatf("m%0d_rd_timeout", n));
                    break;
                end
            end
            @(posedge clk);
            #1;
            m_ren[n] = 1'b0;
        end
    endtask

    task automatic rand_master(input int n, input int cnt);
        int t;
        repeat (cnt) begin
            t = $urandom_range(0, 2);
            txn(n, t != 1, t != 0, 16'($urandom), $urandom,
                4'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic chk_log(string nm, input int base, input int cnt,
                           input logic [2:0] e0, input logic [2:0] e1,
                           input logic [2:0] e2, input logic [2:0] e3);
        logic [2:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({nm, "_ngrants"}, glog.size() - base, cnt);
        for (int i = 0; i < cnt; i++) begin
            if (base + i < glog.size())
                chk($sformatf("%s_grant%0d", nm, i), glog[base + i], e[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        for (int n = 0; n < 2; n++) begin
            m_waddr[n] = '0; m_wdata[n] = '0; m_wstrb[n] = '0;
            m_wen[n] = 1'b0; m_raddr[n] = '0; m_ren[n] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_lb_wen", lb_wen, 0);
        chk("rst_lb_ren", lb_ren, 0);
        chk("rst_m0_rdata", m_rdata[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Contention right after reset, twice: m0 first both times.
        b = glog.size();
        fork
            txn(0, 1, 0, 16'h0100, 32'h01010101, 4'hF, 16'h0);
            txn(1, 1, 0, 16'h0104, 32'h02020202, 4'h3, 16'h0);
        join
        fork
            txn(0, 1, 0, 16'h0108, 32'h03030303, 4'h1, 16'h0);
            txn(1, 1, 0, 16'h010c, 32'h04040404, 4'h8, 16'h0);
        join
        repeat (3) @(posedge clk);
        chk_log("contend", b, 4, 3'b101, 3'b110, 3'b101, 3'b110);

        // Mixed: m0 write+read, m1 read, strictly alternating.
        b = glog.size();
        fork
            txn(0, 1, 1, 16'h0020, 32'h11112222, 4'hF, 16'h0024);
            txn(1, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0014);
        join
        repeat (3) @(posedge clk);
        chk_log("mixed", b, 3, 3'b101, 3'b010, 3'b001, 3'b000);

        // Single write, slave ready at once.
        smode = 1;
        fixed_wait = 0;
        b = glog.size();
        txn(0, 1, 0, 16'h0004, 32'hdeadbeef, 4'hF, 16'h0);
        repeat (3) @(posedge clk);
        chk_log("single_wr", b, 1, 3'b101, 3'b000, 3'b000, 3'b000);
        chk("single_wr_cycles", last_run, 1);

        // Write with five wait states.
        fixed_wait = 5;
        b = glog.size();
        txn(1, 1, 0, 16'h0010, 32'h00acce55, 4'h6, 16'h0);
        repeat (3) @(posedge clk);
        chk_log("wait_wr", b, 1, 3'b110, 3'b000, 3'b000, 3'b000);
        chk("wait_wr_cycles", last_run, 6);

        // Read with five wait states.
        b = glog.size();
        txn(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0008);
        repeat (3) @(posedge clk);
        chk_log("wait_rd", b, 1, 3'b001, 3'b000, 3'b000, 3'b000);

        // Granted master abandons its read.
        smode = 2;
        @(posedge clk);
        #1;
        m_raddr[1] = 16'h0030;
        m_ren[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_ren[1] = 1'b0;
        @(negedge clk);
        chk("drop_lb_ren", lb_ren, 0);
        @(negedge clk);
        chk("drop_gnt", gnt, 0);

        // Reset in the middle of a read, then a late rvalid.
        @(posedge clk);
        #1;
        m_raddr[0] = 16'h0008;
        m_ren[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_ren[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        smode = 3;
        @(negedge clk);
        chk("rstmid_gnt", gnt, 0);
        chk("rstmid_lb_ren", lb_ren, 0);
        repeat (3) @(posedge clk);
        smode = 0;

        // Random traffic with stray slave handshakes.
        spur_en = 1'b1;
        fork
            rand_master(0, 60);
            rand_master(1, 60);
        join
        repeat (5) @(posedge clk);
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("m%0d_wq_drained", n), wq[n].size(), 0);
            chk($sformatf("m%0d_rq_drained", n), rq[n].size(), 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lb_arbiter.md
LB_ARBITER -- requirements
Module: lb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: local bus address width.
REQ-002 SHALL have parameter DATA_W, default 32: local bus data width; STRB_W = DATA_W/8.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have, for N = 0, 1, the following upstream ports, one per signal:
- mN_lb_waddr, input, ADDR_W: master N write address.
- mN_lb_wdata, input, DATA_W: master N write data.
- mN_lb_wstrb, input, STRB_W: master N byte strobes.
- mN_lb_wen, input, 1: master N write request, held until mN_lb_wready.
- mN_lb_wready, output, 1: master N write accepted.
- mN_lb_raddr, input, ADDR_W: master N read address.
- mN_lb_ren, input, 1: master N read request, held until mN_lb_rvalid.
- mN_lb_rdata, output, DATA_W: master N read data.
- mN_lb_rvalid, output, 1: master N read data valid.
REQ-006 SHALL have the following downstream ports, each with the same width and meaning as the mN_ equivalent, with direction reversed:
- lb_waddr, lb_wdata, lb_wstrb, lb_wen: outputs.
- lb_wready: input.
- lb_raddr, lb_ren: outputs.
- lb_rdata, lb_rvalid: inputs.
REQ-007 SHALL have port gnt, output, 2: one-hot grant, bit N = master N owns the bus; 0 = idle.

Function
REQ-008 SHALL implement the FSM states IDLE, WR and RD, plus a registered grant index gnt_idx and last-winner flag last.
REQ-009 SHALL treat master N as requesting when mN_lb_wen | mN_lb_ren.
REQ-010 In IDLE with requests present, SHALL select a winner and register gnt_idx in that cycle; the FSM goes to WR if the winner's wen=1, else RD.
- If both wen and ren are set for the winner, write wins.
REQ-011 Winner selection SHALL be round-robin:
- If only one master requests, it wins.
- If both request, the master != last wins.
- On each grant, last := winner.
REQ-012 In IDLE, SHALL drive lb_wen=0, lb_ren=0, gnt=0, and all mN_lb_wready, mN_lb_rvalid = 0.
REQ-013 In WR, SHALL forward the granted master's waddr/wdata/wstrb/wen combinationally to lb_*; mN_lb_wready = lb_wready for the granted master only; lb_ren=0.
REQ-014 In RD, SHALL forward the granted master's raddr/ren combinationally to lb_*; granted mN_lb_rvalid = lb_rvalid and mN_lb_rdata = lb_rdata; lb_wen=0.
REQ-015 Non-granted masters SHALL see wready=0, rvalid=0, rdata=0 in all states.
REQ-016 Completion SHALL be defined as follows; the FSM returns to IDLE on the following edge:
- WR completes on a cycle with lb_wen && lb_wready.
- RD completes on a cycle with lb_ren && lb_rvalid.
REQ-017 Arbitration latency SHALL be exactly one cycle: a request seen in IDLE at edge k is forwarded downstream from cycle k+1.
- After completion, one IDLE cycle SHALL always precede the next grant, so back-to-back accesses are spaced at least 2 cycles.
REQ-018 If the granted master drops its request (wen in WR, ren in RD) before completion, the FSM SHALL return to IDLE on the next edge with no downstream access issued that cycle.
REQ-019 Requests from the non-granted master SHALL be held pending and never lost; they are served in the next IDLE cycle.
REQ-020 lb_wready or lb_rvalid asserted while the FSM is in IDLE, or not matching the current state, SHALL be ignored and not forwarded.
REQ-021 gnt SHALL be registered state and equal one-hot(gnt_idx) in WR/RD.

Reset
REQ-022 While rst=1 at a clock edge, SHALL set state := IDLE, gnt := 0 and last := 1, so master 0 wins the first contended arbitration.
REQ-023 During and after reset, SHALL drive all outputs as in IDLE: lb_wen=0, lb_ren=0, wready=0, rvalid=0, rdata=0.
REQ-024 Reset asserted mid-transaction SHALL abort it; no completion SHALL be signalled to either master.

Verification
REQ-025 Single write: m0 writes addr 0x004, data 0xdeadbeef, strb 0xF, with lb_wready=1 -> lb_wen one cycle after request with matching fields; m0_lb_wready pulses once; gnt=01 then 00.
REQ-026 Write wait states: m1 writes addr 0x010, data 0x0acce55, strb 0x6, with lb_wready=0 for 5 cycles -> lb_* held stable for 6 cycles; m1_lb_wready only on the accepting cycle; m0 sees nothing.
REQ-027 Read wait states: m0 reads 0x008; slave returns rvalid with 0xdeadbeef after 5 cycles -> m0_lb_rdata=0xdeadbeef with m0_lb_rvalid; m1_lb_rdata=0 throughout.
REQ-028 Contention: m0 and m1 both write on the first cycle after reset -> m0 granted first, m1 second; next simultaneous pair -> m0 first again (last=1 after the m1 grant).
REQ-029 Mixed: m0 holds wen and ren together; m1 reads 0x014 returning 0xc0debabe -> m0 write, then m1 read, then m0 read, strictly alternating, with no lost request.
REQ-030 Reset mid-read: assert rst for 1 cycle while in RD before rvalid -> gnt=0 and lb_ren=0 next cycle; a late lb_rvalid is not forwarded to either master.
